// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART pin-register command master and its RX helper.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_CMD,
    ST_TX_DATA,
    ST_RX_WAIT,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BADACK  = 2'b10;
  localparam logic [1:0] ERR_FRAME   = 2'b11;

  localparam int RD_BIT   = 7;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 3;

  function automatic logic [7:0] mk_cmd(input logic rd, input logic [ADDR_W-1:0] addr);
    logic [7:0] c;
    c                      = '0;
    c[RD_BIT]              = rd;
    c[ADDR_LSB +: ADDR_W]  = addr;
    return c;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, half-bit start re-check, bit-centre sampling.
// Held idle (and disarmed) while enable is low so only a fresh start edge is taken.
module uart_rx_byte
  import uart_cmd_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       uart_rxd,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err,
  output logic       active
);

  localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  rx_state_e        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             armed_q, armed_d;
  logic             meta_q, sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
    end else begin
      meta_q  <= uart_rxd;
      sync_q  <= meta_q;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (!enable) begin
      st_d    = RX_IDLE;
      cnt_d   = '0;
      armed_d = 1'b0;
    end else begin
      case (st_q)
        RX_IDLE: begin
          cnt_d   = '0;
          // a start is a high-to-low transition seen while enabled
          armed_d = sync_q;
          if (armed_q && !sync_q) st_d = RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            bit_d = '0;
            st_d  = sync_q ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            shift_d = {sync_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) st_d = RX_STOP;
          end
        end
        RX_STOP: begin
          if (cnt_q == LAST) begin
            byte_valid = 1'b1;
            frame_err  = !sync_q;
            armed_d    = 1'b0;
            st_d       = RX_IDLE;
          end
        end
        default: st_d = RX_IDLE;
      endcase
    end
  end

  assign byte_data = shift_q;
  assign active    = (st_q != RX_IDLE);

endmodule

// File: rtl/uart_cmd_master.sv
// Host-side initiator for the single-byte UART pin-register protocol: sends a command
// (plus data for writes), then waits for the responder's echo/read byte or a timeout.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int TIMEOUT_CYC = 500_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rd,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [7:0]          req_wdata,
  output logic                rsp_valid,
  output logic [7:0]          rsp_rdata,
  output logic [1:0]          rsp_err,
  output logic                busy,
  input  logic                uart_rxd,
  output logic                uart_txd
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int TO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(BAUD_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC);

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [8:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bitn_q, bitn_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [1:0]       err_q, err_d;

  logic       rx_valid, rx_ferr, rx_active;
  logic [7:0] rx_data;

  uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .enable     (state_q == ST_RX_WAIT),
    .uart_rxd   (uart_rxd),
    .byte_valid (rx_valid),
    .byte_data  (rx_data),
    .frame_err  (rx_ferr),
    .active     (rx_active)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      wdata_q <= '0;
      shift_q <= '1;
      txd_q   <= 1'b1;
      baud_q  <= '0;
      bitn_q  <= '0;
      to_q    <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      baud_q  <= baud_d;
      bitn_q  <= bitn_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    baud_d  = baud_q;
    bitn_d  = bitn_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cmd_d   = mk_cmd(req_rd, req_addr);
          wdata_d = req_wdata;
          shift_d = {1'b1, mk_cmd(req_rd, req_addr)};
          txd_d   = 1'b0;
          baud_d  = '0;
          bitn_d  = '0;
          state_d = ST_TX_CMD;
        end
      end
      ST_TX_CMD, ST_TX_DATA: begin
        baud_d = baud_q + CNT_W'(1);
        if (baud_q == LAST) begin
          baud_d = '0;
          if (bitn_q == 4'd9) begin
            // stop bit done: chain the data byte with no gap, or start listening
            if (state_q == ST_TX_CMD && !cmd_q[RD_BIT]) begin
              shift_d = {1'b1, wdata_q};
              txd_d   = 1'b0;
              bitn_d  = '0;
              state_d = ST_TX_DATA;
            end else begin
              to_d    = '0;
              state_d = ST_RX_WAIT;
            end
          end else begin
            txd_d   = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
            bitn_d  = bitn_q + 4'd1;
          end
        end
      end
      ST_RX_WAIT: begin
        if (rx_valid) begin
          rdata_d = rx_data;
          state_d = ST_DONE;
          if (rx_ferr)                                  err_d = ERR_FRAME;
          else if (!cmd_q[RD_BIT] && rx_data != cmd_q)  err_d = ERR_BADACK;
          else                                          err_d = ERR_OK;
        end else if (!rx_active) begin
          if (to_q == TO_LAST) begin
            rdata_d = '0;
            err_d   = ERR_TIMEOUT;
            state_d = ST_DONE;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = !req_ready;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign uart_txd  = txd_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench: decodes uart_txd at bit centres, plays the responder on uart_rxd.
module tb_uart_cmd_master;

  localparam int D  = 434;
  localparam int TO = 1000;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       req_valid, req_rd, req_ready, rsp_valid, busy, uart_rxd, uart_txd;
  logic [2:0] req_addr;
  logic [7:0] req_wdata, rsp_rdata;
  logic [1:0] rsp_err;

  int         cyc = 0;
  int         n_chk = 0, n_err = 0;
  int         rsp_cnt = 0, rsp_cyc = 0;
  logic [7:0] rsp_data_l = '0;
  logic [1:0] rsp_err_l = '0;

  uart_cmd_master #(.CLK_FREQ(50_000_000), .BAUD(115200), .TIMEOUT_CYC(TO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .uart_rxd  (uart_rxd),
    .uart_txd  (uart_txd)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (rsp_valid) begin
      rsp_cnt    <= rsp_cnt + 1;
      rsp_cyc    <= cyc;
      rsp_data_l <= rsp_rdata;
      rsp_err_l  <= rsp_err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge sys_clk);
  endtask

  task automatic issue(input logic rd, input logic [2:0] a, input logic [7:0] wd, output int s);
    @(negedge sys_clk);
    req_valid = 1'b1; req_rd = rd; req_addr = a; req_wdata = wd;
    @(posedge sys_clk);
    #1;
    s = cyc;
    req_valid = 1'b0;
    chk("ready_drop", req_ready, 1'b0);
    chk("busy_set", busy, 1'b1);
    chk("start_bit", uart_txd, 1'b0);
  endtask

  task automatic tx_get(input int s, output logic [7:0] b);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(s + (i + 1) * D + D / 2);
      v[i] = uart_txd;
    end
    wait_cyc(s + 9 * D + D / 2);
    chk("tx_stop", uart_txd, 1'b1);
    b = v;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stopb);
    @(negedge sys_clk);
    uart_rxd = 1'b0;
    repeat (D) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (D) @(negedge sys_clk);
    end
    uart_rxd = stopb;
    repeat (D) @(negedge sys_clk);
    uart_rxd = 1'b1;
  endtask

  task automatic wait_rsp(input int prev, input int budget, input string tag);
    int n;
    n = 0;
    while (rsp_cnt == prev && n < budget) begin
      @(negedge sys_clk);
      #1;
      n++;
    end
    chk(tag, rsp_cnt - prev, 1);
  endtask

  task automatic rsp_chk(input int prev, input logic [7:0] d, input logic [1:0] e);
    repeat (5) @(negedge sys_clk);
    #1;
    chk("rsp_pulses", rsp_cnt - prev, 1);
    chk("rsp_rdata", rsp_data_l, d);
    chk("rsp_err", rsp_err_l, e);
    chk("rsp_hold", rsp_rdata, d);
    chk("ready_back", req_ready, 1'b1);
  endtask

  initial begin
    int s, prev;
    logic [7:0] b;
    sys_rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_addr = '0; req_wdata = '0; uart_rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_vld", rsp_valid, 1'b0);
    chk("rst_rdata", rsp_rdata, 8'h00);
    chk("rst_err", rsp_err, 2'b00);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // write addr 2, 0xA5, good echo
    issue(1'b0, 3'd2, 8'hA5, s);
    tx_get(s, b);
    chk("w1_cmd", b, 8'h02);
    wait_cyc(s + 10 * D - 1);
    chk("w1_stop_last", uart_txd, 1'b1);
    wait_cyc(s + 10 * D);
    chk("w1_data_start", uart_txd, 1'b0);
    tx_get(s + 10 * D, b);
    chk("w1_data", b, 8'hA5);
    wait_cyc(s + 20 * D + 20);
    prev = rsp_cnt;
    rx_send(8'h02, 1'b1);
    wait_rsp(prev, 4 * D, "w1_rsp_seen");
    rsp_chk(prev, 8'h02, 2'b00);

    // read addr 0, reply 0x3C
    issue(1'b1, 3'd0, 8'h00, s);
    tx_get(s, b);
    chk("r1_cmd", b, 8'h80);
    wait_cyc(s + 10 * D + 20);
    prev = rsp_cnt;
    rx_send(8'h3C, 1'b1);
    wait_rsp(prev, 4 * D, "r1_rsp_seen");
    rsp_chk(prev, 8'h3C, 2'b00);

    // read addr 4, no reply -> timeout
    issue(1'b1, 3'd4, 8'h00, s);
    tx_get(s, b);
    chk("to_cmd", b, 8'h84);
    prev = rsp_cnt;
    wait_rsp(prev, D + TO + 100, "to_rsp_seen");
    chk("to_latency", rsp_cyc, s + 10 * D + TO + 1);
    rsp_chk(prev, 8'h00, 2'b01);

    // write addr 1, 0x11, wrong echo
    issue(1'b0, 3'd1, 8'h11, s);
    tx_get(s, b);
    chk("w2_cmd", b, 8'h01);
    tx_get(s + 10 * D, b);
    chk("w2_data", b, 8'h11);
    wait_cyc(s + 20 * D + 20);
    prev = rsp_cnt;
    rx_send(8'h55, 1'b1);
    wait_rsp(prev, 4 * D, "w2_rsp_seen");
    rsp_chk(prev, 8'h55, 2'b10);

    // read reserved addr 6, reply with low stop bit
    issue(1'b1, 3'd6, 8'h00, s);
    tx_get(s, b);
    chk("fe_cmd", b, 8'h86);
    wait_cyc(s + 10 * D + 20);
    prev = rsp_cnt;
    rx_send(8'hF0, 1'b0);
    wait_rsp(prev, 4 * D, "fe_rsp_seen");
    rsp_chk(prev, 8'hF0, 2'b11);

    // reset during data bit 3 of a write command byte
    issue(1'b0, 3'd3, 8'h5A, s);
    wait_cyc(s + 4 * D + D / 2);
    chk("rst_pre_txd", uart_txd, 1'b0);
    prev = rsp_cnt;
    #1 sys_rst = 1'b1;
    #1 chk("rst_async_txd", uart_txd, 1'b1);
    repeat (3) @(negedge sys_clk);
    chk("rst_mid_rdata", rsp_rdata, 8'h00);
    chk("rst_mid_err", rsp_err, 2'b00);
    sys_rst = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("rst_rel_ready", req_ready, 1'b1);
    chk("rst_rel_busy", busy, 1'b0);
    repeat (3 * D) @(negedge sys_clk);
    chk("rst_no_rsp", rsp_cnt - prev, 0);
    chk("rst_txd_idle", uart_txd, 1'b1);

    // normal read after the abort
    issue(1'b1, 3'd5, 8'h00, s);
    tx_get(s, b);
    chk("r2_cmd", b, 8'h85);
    wait_cyc(s + 10 * D + 20);
    prev = rsp_cnt;
    rx_send(8'h77, 1'b1);
    wait_rsp(prev, 4 * D, "r2_rsp_seen");
    rsp_chk(prev, 8'h77, 2'b00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
